// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Purpose:
//   Central sequencer for the 5-stage pipeline. It replaces the hard-wired
//   enable_pc / enable_ifid / S (control NOP mux select) signals. It does four
//   things:
//   - holds the pipeline idle for INIT_CYCLES after reset so memory preload can
//     finish
//   - inserts one bubble on a load-use hazard
//   - flushes IF/ID on a taken branch
//   - freezes the pipeline while data memory is busy, and raises a sticky error
//     if the wait runs longer than MEM_TIMEOUT cycles
//
// Handshake with data memory:
//   - mem_req is held high by the MEM stage for as long as it owns an access.
//   - The access completes in the cycle where mem_ready=1.
//   - A cycle with mem_req=1 and mem_ready=0 is a wait cycle.
//   - If mem_req drops while waiting, the access counts as done.
//
// Ports:
//   clk               in   system clock, rising edge
//   reset             in   asynchronous, active-high reset
//   id_rn, id_rm      in   ID-stage source registers
//   id_uses_rn/rm     in   ID instruction actually reads Rn / Rm
//   ex_load           in   EX-stage instruction is a load
//   ex_rf_e           in   EX-stage instruction writes the register file
//   ex_rd             in   EX-stage destination register
//   id_branch_taken   in   branch/BL resolved taken in ID this cycle
//   mem_req           in   MEM stage is accessing data memory
//   mem_ready         in   data memory completes the access this cycle
//   enable_pc         out  PC load enable
//   enable_ifid       out  IF/ID register load enable
//   flush_ifid        out  clear IF/ID to an all-zero NOP on the next edge
//   nop_sel           out  1 = feed all-zero control signals into ID/EX
//   freeze_late       out  hold ID/EX, EX/MEM and MEM/WB
//   mem_err           out  sticky memory-timeout flag
//   stall_count       out  saturating count of stalled cycles (RUN/MEM_WAIT)
//   state             out  current FSM state: 0 INIT, 1 RUN, 2 MEM_WAIT, 3 ERROR
// ---------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter int INIT_CYCLES = 4,   // 1..255
  parameter int MEM_TIMEOUT = 15,  // 1..255
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       id_rn,
  input  logic [3:0]       id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             ex_load,
  input  logic             ex_rf_e,
  input  logic [3:0]       ex_rd,
  input  logic             id_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             enable_pc,
  output logic             enable_ifid,
  output logic             flush_ifid,
  output logic             nop_sel,
  output logic             freeze_late,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  localparam logic [7:0]       INIT_LAST = 8'(INIT_CYCLES - 1);
  localparam logic [7:0]       TIMEOUT   = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1);

  // -------------------------------------------------------------------------
  // Registered state
  // -------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [7:0]       init_cnt_q, init_cnt_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // -------------------------------------------------------------------------
  // Hazard / memory condition decode
  // -------------------------------------------------------------------------
  logic rn_hit;
  logic rm_hit;
  logic load_use;
  logic mem_stall;
  logic mem_done;

  assign rn_hit    = id_uses_rn & (id_rn == ex_rd);
  assign rm_hit    = id_uses_rm & (id_rm == ex_rd);
  // The loaded value is not available until after MEM. Only a load that
  // actually writes the register file can create the dependency.
  assign load_use  = ex_load & ex_rf_e & (rn_hit | rm_hit);
  assign mem_stall = mem_req & ~mem_ready;
  // A dropped request ends the wait just like a ready does.
  assign mem_done  = mem_ready | ~mem_req;

  // -------------------------------------------------------------------------
  // Mealy outputs and next-state logic
  // -------------------------------------------------------------------------
  logic pc_en;
  logic ifid_en;
  logic flush;
  logic nop;
  logic freeze;

  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    flush      = 1'b0;
    nop        = 1'b0;
    freeze     = 1'b0;
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;

    case (state_q)
      ST_INIT: begin
        // Pipeline idle: no fetch, only bubbles reach ID/EX.
        nop        = 1'b1;
        init_cnt_d = init_cnt_q + 8'd1;
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (mem_stall) begin
          // The memory wait wins over everything else. The instructions in the
          // front of the pipeline simply hold. No bubble is needed, because
          // ID/EX is frozen as well.
          freeze     = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else if (load_use) begin
          // One bubble. Next cycle the load is in MEM, so the hazard is gone.
          // A coincident taken branch is dropped here; it resolves again next
          // cycle from the held IF/ID contents.
          nop = 1'b1;
        end else if (id_branch_taken) begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
          flush   = 1'b1;
        end else begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        // Everything is held. Hazard and branch inputs reflect frozen stages
        // and are ignored until the access completes.
        freeze = 1'b1;
        if (mem_done) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == TIMEOUT) begin
          state_d   = ST_ERROR;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      ST_ERROR: begin
        // Dead end until reset.
        nop    = 1'b1;
        freeze = 1'b1;
      end

      default: begin
        state_d = ST_INIT;
        nop     = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Stall performance counter
  // -------------------------------------------------------------------------
  logic stall_event;

  // INIT and ERROR also hold the PC, but those are not pipeline stalls.
  assign stall_event = ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) & ~pc_en;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_event && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + STALL_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= 8'd0;
      wait_cnt_q  <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output drive
  // -------------------------------------------------------------------------
  assign enable_pc   = pc_en;
  assign enable_ifid = ifid_en;
  assign flush_ifid  = flush;
  assign nop_sel     = nop;
  assign freeze_late = freeze;
  assign mem_err     = mem_err_q;
  assign stall_count = stall_cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_controller
//
// Bench for pipeline_hazard_controller.
// - The driver applies one input set per cycle, just after the rising edge.
// - For each input set, the driver pushes the expected output vector into
//   exp_q. That vector comes from a cycle-level reference model.
// - The monitor pops one entry on each falling edge and compares it with the
//   DUT outputs.
// - Directed sequences cover reset, INIT, load-use, branch, memory wait,
//   timeout and async reset. A randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

  localparam int INIT_CYCLES = 4;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 16;
  localparam int W           = 8 + CNT_W;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  logic [3:0] id_rn, id_rm, ex_rd;
  logic id_uses_rn, id_uses_rm, ex_load, ex_rf_e, id_branch_taken;
  logic mem_req, mem_ready;
  logic enable_pc, enable_ifid, flush_ifid, nop_sel, freeze_late, mem_err;
  logic [CNT_W-1:0] stall_count;
  logic [1:0] state;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(
    .INIT_CYCLES(INIT_CYCLES),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rn          (id_rn),
    .id_rm          (id_rm),
    .id_uses_rn     (id_uses_rn),
    .id_uses_rm     (id_uses_rm),
    .ex_load        (ex_load),
    .ex_rf_e        (ex_rf_e),
    .ex_rd          (ex_rd),
    .id_branch_taken(id_branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .enable_pc      (enable_pc),
    .enable_ifid    (enable_ifid),
    .flush_ifid     (flush_ifid),
    .nop_sel        (nop_sel),
    .freeze_late    (freeze_late),
    .mem_err        (mem_err),
    .stall_count    (stall_count),
    .state          (state)
  );

  typedef struct packed {
    logic [3:0] rn;
    logic [3:0] rm;
    logic       urn;
    logic       urm;
    logic       ld;
    logic       rfe;
    logic [3:0] rd;
    logic       br;
    logic       req;
    logic       rdy;
  } stim_t;

  // -------------------------------------------------------------------------
  // Reference model: spec-level bookkeeping
  //   m_mode      spec state code (0 INIT, 1 RUN, 2 MEM_WAIT, 3 ERROR)
  //   m_edges     edges seen since reset release (INIT length)
  //   m_streak    consecutive memory-wait cycles, counting the RUN cycle
  //               that started the wait
  // -------------------------------------------------------------------------
  int m_mode, m_edges, m_streak, m_stalls;
  bit m_err;

  function automatic void model_reset();
    m_mode   = 0;
    m_edges  = 0;
    m_streak = 0;
    m_stalls = 0;
    m_err    = 1'b0;
  endfunction

  function automatic bit is_load_use(stim_t s);
    return s.ld && s.rfe && ((s.urn && s.rn == s.rd) || (s.urm && s.rm == s.rd));
  endfunction

  // Output vector layout: {pc, ifid, flush, nop, freeze, err, state[1:0], stalls}
  function automatic logic [W-1:0] model_out(stim_t s);
    logic pc, ifid, fl, nop, frz;
    pc = 0; ifid = 0; fl = 0; nop = 0; frz = 0;
    if (m_mode == 0) begin
      nop = 1;
    end else if (m_mode == 1) begin
      if (s.req && !s.rdy)     frz = 1;
      else if (is_load_use(s)) nop = 1;
      else if (s.br)           begin pc = 1; ifid = 1; fl = 1; end
      else                     begin pc = 1; ifid = 1; end
    end else if (m_mode == 2) begin
      frz = 1;
    end else begin
      nop = 1; frz = 1;
    end
    return {pc, ifid, fl, nop, frz, m_err, 2'(m_mode), CNT_W'(m_stalls)};
  endfunction

  function automatic void count_stall();
    if (m_stalls < (1 << CNT_W) - 1) m_stalls++;
  endfunction

  function automatic void model_edge(stim_t s);
    case (m_mode)
      0: begin
        m_edges++;
        if (m_edges == INIT_CYCLES) m_mode = 1;
      end
      1: begin
        if (s.req && !s.rdy) begin
          count_stall();
          m_streak = 1;
          m_mode   = 2;
        end else if (is_load_use(s)) begin
          count_stall();
        end
      end
      2: begin
        count_stall();
        if (!s.req || s.rdy) begin
          m_mode = 1;
        end else begin
          m_streak++;
          // Timeout after MEM_TIMEOUT+1 stalled cycles in total.
          if (m_streak == MEM_TIMEOUT + 1) begin
            m_mode = 3;
            m_err  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(negedge clk) begin
    logic [W-1:0] got, exp_v;
    cyc++;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got   = {enable_pc, enable_ifid, flush_ifid, nop_sel, freeze_late,
               mem_err, state, stall_count};
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got pc=%b ifid=%b flush=%b nop=%b frz=%b err=%b st=%0d stalls=%0d, exp pc=%b ifid=%b flush=%b nop=%b frz=%b err=%b st=%0d stalls=%0d",
                 cyc, got[W-1], got[W-2], got[W-3], got[W-4], got[W-5], got[W-6],
                 got[CNT_W+1:CNT_W], got[CNT_W-1:0],
                 exp_v[W-1], exp_v[W-2], exp_v[W-3], exp_v[W-4], exp_v[W-5], exp_v[W-6],
                 exp_v[CNT_W+1:CNT_W], exp_v[CNT_W-1:0]);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic drive(stim_t s);
    id_rn           = s.rn;
    id_rm           = s.rm;
    id_uses_rn      = s.urn;
    id_uses_rm      = s.urm;
    ex_load         = s.ld;
    ex_rf_e         = s.rfe;
    ex_rd           = s.rd;
    id_branch_taken = s.br;
    mem_req         = s.req;
    mem_ready       = s.rdy;
  endtask

  // One cycle: apply inputs, predict outputs, advance the model on the edge.
  task automatic step(stim_t s);
    drive(s);
    exp_q.push_back(model_out(s));
    @(posedge clk);
    model_edge(s);
    #1;
  endtask

  // Reset is raised between edges. The first check falls before any clock
  // edge, so it sees the asynchronous effect.
  task automatic do_reset(int cycles);
    stim_t z;
    z = '0;
    drive(z);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < cycles; i++) begin
      exp_q.push_back(model_out(z));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    stim_t s, z;
    int burst;
    z     = '0;
    burst = 0;
    reset = 1'b1;
    drive(z);
    model_reset();
    @(posedge clk);
    #1;

    // INIT hold
    do_reset(3);
    repeat (INIT_CYCLES) step(z);
    repeat (2) step(z);

    // Load-use on Rm, then no hazard when the registers differ
    s = z; s.ld = 1; s.rfe = 1; s.rd = 4'd3; s.urm = 1; s.rm = 4'd3;
    step(s);
    step(z);
    s.rm = 4'd5;
    step(s);
    // Load-use on Rn; then the same stimulus with rf_e low causes no stall
    s = z; s.ld = 1; s.rfe = 1; s.rd = 4'd7; s.urn = 1; s.rn = 4'd7;
    step(s);
    s.rfe = 0;
    step(s);

    // Branch alone, then branch coincident with load-use
    s = z; s.br = 1;
    step(s);
    step(z);
    s = z; s.ld = 1; s.rfe = 1; s.rd = 4'd3; s.urm = 1; s.rm = 4'd3; s.br = 1;
    step(s);
    s.ld = 0;
    step(s);
    step(z);

    // Memory wait: 3 wait cycles, then ready
    s = z; s.req = 1;
    repeat (3) step(s);
    s.rdy = 1;
    step(s);
    step(z);

    // Request dropped mid-wait, with a hazard present during the wait
    s = z; s.req = 1;
    step(s);
    s.req = 0; s.ld = 1; s.rfe = 1; s.urn = 1;
    s.req = 1; step(s);
    s.req = 0;
    step(s);
    step(z);

    // Timeout: held wait into ERROR; outputs stay frozen; then reset
    s = z; s.req = 1;
    repeat (18) step(s);
    s.rdy = 1; s.br = 1;
    step(s);
    step(z);
    do_reset(2);
    repeat (INIT_CYCLES + 2) step(z);

    // Async reset during MEM_WAIT, between edges
    s = z; s.req = 1;
    repeat (3) step(s);
    #2;
    do_reset(1);
    repeat (INIT_CYCLES + 3) step(z);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      if ((m_mode == 3 && $urandom_range(0, 3) == 0) || $urandom_range(0, 499) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        s.rn  = 4'($urandom_range(0, 3));
        s.rm  = 4'($urandom_range(0, 3));
        s.rd  = 4'($urandom_range(0, 3));
        s.urn = 1'($urandom_range(0, 1));
        s.urm = 1'($urandom_range(0, 1));
        s.ld  = ($urandom_range(0, 2) == 0);
        s.rfe = ($urandom_range(0, 3) != 0);
        s.br  = ($urandom_range(0, 4) == 0);
        if (burst > 0) begin
          burst--;
          s.req = 1; s.rdy = 0;
        end else if ($urandom_range(0, 39) == 0) begin
          burst = int'($urandom_range(1, 20));
          s.req = 1; s.rdy = 0;
        end else begin
          s.req = ($urandom_range(0, 3) == 0);
          s.rdy = ($urandom_range(0, 2) != 0);
        end
        step(s);
      end
    end

    // Drain: every expectation must have been consumed by the monitor
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
